processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameters: none; all widths fixed as below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-high (rst_n=1 resets on the next rising edge of clk).
REQ-004 ena  input  1  execution enable; 0 = stall.
REQ-005 instr  input  32  instruction at address pc; [7:0] opcode, [15:8] ignored, [31:16] 16-bit operand.
REQ-006 pc  output  8  program counter, registered.
REQ-007 ctrl_fill  output  1  water-fill valve drive, registered.
REQ-008 ctrl_release  output  1  drain valve drive, registered.
REQ-009 ctrl_forward  output  1  motor forward drive, registered.
REQ-010 ctrl_reverse  output  1  motor reverse drive, registered.

Function
REQ-011 Opcodes SHALL be: 0x01 WAIT, 0x02 FILL, 0x03 RELEASE, 0x04 FORWARD, 0x05 REVERSE, 0x11 SET, 0x12 DEC, 0x21 JZ; all other opcodes execute as a 1-cycle NOP (pc+1).
REQ-012 States SHALL be FETCH and EXEC; instr is sampled only in FETCH, and instr is read combinationally from external memory addressed by pc.
REQ-013 Timed ops (WAIT/FILL/RELEASE/FORWARD/REVERSE) with operand N>0: FETCH -> EXEC, timer <= N-1; the op's ctrl output (none for WAIT) is 1 for exactly N cycles starting the cycle after FETCH.
REQ-014 In EXEC with timer=0: ctrl output -> 0, pc <= pc+1, return to FETCH; otherwise timer decrements; total op time N+1 cycles.
REQ-015 Timed op with N=0: no output pulse, pc <= pc+1, stays in FETCH (1 cycle).
REQ-016 At most one ctrl_* output SHALL be 1 in any cycle.
REQ-017 SET: 16-bit counter register cnt <= operand, pc+1, 1 cycle.
REQ-018 DEC: cnt <= cnt-1 (boundary per REQ-025/026), pc+1, 1 cycle.
REQ-019 JZ: if cnt==0 then pc <= operand[7:0], else pc <= pc+1; 1 cycle; cnt unchanged.
REQ-020 pc increment SHALL wrap 0xFF -> 0x00.
REQ-021 ena=0: state, pc, cnt, timer and all outputs hold; resumes exactly where stalled when ena=1.

Reset
REQ-022 Reset SHALL set pc=0x00, cnt=0x0000, timer=0, state=FETCH, all ctrl_* = 0.
REQ-023 Reset SHALL take priority over ena and abort any in-progress EXEC immediately (outputs 0 after that edge).

Configuration
REQ-024 Macro PROCESSOR_DEC_SAT_EN selects DEC underflow behaviour.
REQ-025 Defined: DEC with cnt=0 leaves cnt=0 (saturating).
REQ-026 Undefined: DEC with cnt=0 wraps cnt to 0xFFFF.

Verification
REQ-027 Reset, then instr={0x0020,0x00,0x02} -> ctrl_fill=1 for exactly 32 cycles, pc 0->1 after 33 cycles, other ctrl outputs 0.
REQ-028 Sequence RELEASE 0x30, FORWARD 0x40, REVERSE 0x50, WAIT 0x60 -> respective output high 48/64/80/0 cycles, pc advances by 1 after each (N+1 cycles).
REQ-029 SET 0x00AB, DEC, JZ 0x00CD -> cnt=0xAA, JZ not taken, pc+1; then SET 0x0000, JZ 0x00EF -> pc=0xEF.
REQ-030 SET 0, DEC -> cnt=0x0000 with PROCESSOR_DEC_SAT_EN, 0xFFFF without.
REQ-031 FILL 10 with ena=0 for 5 cycles mid-op -> ctrl_fill high 10 active cycles (15 wall cycles); rst_n=1 mid-op -> ctrl_fill=0, pc=0 next cycle.

Source files
------------

// File: rtl/processor.sv
// processor: two-state sequencer for washer valves and motor; define PROCESSOR_DEC_SAT_EN to make DEC saturate at zero
module processor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [31:0] instr,
  output logic [7:0]  pc,
  output logic        ctrl_fill,
  output logic        ctrl_release,
  output logic        ctrl_forward,
  output logic        ctrl_reverse
);
  typedef enum logic {FETCH, EXEC} state_t;
  localparam logic [7:0] OP_WAIT = 8'h01, OP_FILL = 8'h02, OP_REVERSE = 8'h05,
                         OP_SET = 8'h11, OP_DEC = 8'h12, OP_JZ = 8'h21;
  state_t      state, state_n;
  logic [7:0]  pc_n, op;
  logic [15:0] cnt, cnt_n, timer, timer_n, opd, cnt_dec;
  logic [3:0]  ctrl, ctrl_n, ctrl_sel;
  logic        timed;
  assign op    = instr[7:0];
  assign opd   = instr[31:16];
  assign timed = op >= OP_WAIT && op <= OP_REVERSE;
  // WAIT drives nothing; the other timed ops map onto one bit each
  assign ctrl_sel = (op >= OP_FILL && op <= OP_REVERSE) ? 4'(32'd1 << (op - OP_FILL)) : 4'b0;
`ifdef PROCESSOR_DEC_SAT_EN
  assign cnt_dec = (cnt == 16'd0) ? cnt : cnt - 16'd1;
`else
  assign cnt_dec = cnt - 16'd1;
`endif
  assign {ctrl_reverse, ctrl_forward, ctrl_release, ctrl_fill} = ctrl;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    timer_n = timer;
    ctrl_n  = ctrl;
    if (!ena) begin
      state_n = state;
    end else if (state == EXEC) begin
      if (timer == 16'd0) begin
        ctrl_n  = 4'b0;
        pc_n    = pc + 8'd1;
        state_n = FETCH;
      end else begin
        timer_n = timer - 16'd1;
      end
    end else if (timed && opd != 16'd0) begin
      state_n = EXEC;
      timer_n = opd - 16'd1;
      ctrl_n  = ctrl_sel;
    end else begin
      pc_n  = (op == OP_JZ && cnt == 16'd0) ? opd[7:0] : pc + 8'd1;
      cnt_n = op == OP_SET ? opd : op == OP_DEC ? cnt_dec : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= FETCH;
      pc    <= 8'd0;
      cnt   <= 16'd0;
      timer <= 16'd0;
      ctrl  <= 4'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      timer <= timer_n;
      ctrl  <= ctrl_n;
    end
  end
endmodule

// File: tb/tb_processor.sv
// tb_processor: directed program run against processor with a queue of expected results
module tb_processor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b0;
  logic [31:0] instr;
  logic [7:0]  pc;
  logic        ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse;
  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  processor dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .instr(instr), .pc(pc),
    .ctrl_fill(ctrl_fill), .ctrl_release(ctrl_release),
    .ctrl_forward(ctrl_forward), .ctrl_reverse(ctrl_reverse)
  );

  always #5 clk = ~clk;
  assign instr = mem[pc];

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [15:0] opd);
    return {opd, 8'h00, op};
  endfunction

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] exp_pc);
    push({24'd0, exp_pc});
    @(negedge clk);
    check(tag, {24'd0, pc});
  endtask

  // idx 0..3 selects fill/release/forward/reverse, 4 is WAIT
  task automatic timed(input string tag, input int idx, input int n);
    logic [3:0]  mask, c;
    logic [7:0]  p0, p_mid;
    int          hi, other;
    mask = (idx < 4) ? 4'(32'd1 << idx) : 4'b0;
    p0 = pc;
    p_mid = 8'd0;
    hi = 0;
    other = 0;
    push((idx < 4) ? n : 0);
    push(0);
    push({24'd0, p0});
    push({24'd0, p0 + 8'd1});
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      c = {ctrl_reverse, ctrl_forward, ctrl_release, ctrl_fill};
      if ((idx < 4) ? |(c & mask) : |c) hi++;
      if (|(c & ~mask)) other++;
      if (i == n - 1) p_mid = pc;
    end
    check({tag, "_pulse"}, hi);
    check({tag, "_other"}, other);
    check({tag, "_pc_hold"}, {24'd0, p_mid});
    check({tag, "_pc_next"}, {24'd0, pc});
  endtask

  initial begin
    int hi;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h00] = enc(8'h02, 16'h0020);
    mem[8'h01] = enc(8'h03, 16'h0030);
    mem[8'h02] = enc(8'h04, 16'h0040);
    mem[8'h03] = enc(8'h05, 16'h0050);
    mem[8'h04] = enc(8'h01, 16'h0060);
    mem[8'h05] = enc(8'h11, 16'h00AB);
    mem[8'h06] = enc(8'h12, 16'h0000);
    mem[8'h07] = enc(8'h21, 16'h00CD);
    mem[8'h08] = enc(8'h11, 16'h0000);
    mem[8'h09] = enc(8'h21, 16'h00EF);
    mem[8'hEF] = enc(8'h11, 16'h0000);
    mem[8'hF0] = enc(8'h12, 16'h0000);
    mem[8'hF1] = enc(8'h21, 16'h0010);
    mem[8'h10] = enc(8'h21, 16'h00F2);
    mem[8'hF2] = enc(8'h02, 16'h0000);
    mem[8'hF3] = enc(8'h02, 16'h000A);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    push(0); check("rst_pc", {24'd0, pc});
    push(0); check("rst_ctrl", {28'd0, ctrl_reverse, ctrl_forward, ctrl_release, ctrl_fill});
    repeat (3) @(negedge clk);
    push(0); check("stall_pc", {24'd0, pc});
    ena = 1'b1;
    timed("fill32", 0, 32);
    timed("release48", 1, 48);
    timed("forward64", 2, 64);
    timed("reverse80", 3, 80);
    timed("wait96", 4, 96);
    step("set_ab", 8'h06);
    step("dec", 8'h07);
    push(32'h00AA); check("cnt_aa", {16'd0, dut.cnt});
    step("jz_not_taken", 8'h08);
    step("set_0", 8'h09);
    step("jz_taken", 8'hEF);
    step("set_0b", 8'hF0);
    step("dec_zero", 8'hF1);
`ifdef PROCESSOR_DEC_SAT_EN
    push(32'h0000); check("dec_underflow", {16'd0, dut.cnt});
    step("jz_sat", 8'h10);
    step("jz_back", 8'hF2);
`else
    push(32'hFFFF); check("dec_underflow", {16'd0, dut.cnt});
    step("jz_wrap", 8'hF2);
`endif
    step("fill0", 8'hF3);
    push(0); check("fill0_ctrl", {31'd0, ctrl_fill});
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ctrl_fill) hi++;
      if (i == 5) begin
        push({24'd0, 8'hF3});
        check("stall_mid_pc", {24'd0, pc});
      end
      ena = (i >= 2 && i < 7) ? 1'b0 : 1'b1;
    end
    push(15); check("stall_fill_wall", hi);
    push({24'd0, 8'hF4}); check("stall_pc_next", {24'd0, pc});
    for (int a = 8'hF5; a <= 8'hFF; a++) step("nop", 8'(a));
    step("wrap", 8'h00);
    repeat (4) @(negedge clk);
    push(1); check("fill_before_rst", {31'd0, ctrl_fill});
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    push(0); check("rst_mid_fill", {31'd0, ctrl_fill});
    push(0); check("rst_mid_pc", {24'd0, pc});
    push(0); check("rst_mid_cnt", {16'd0, dut.cnt});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
